// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - CPU memory port bundle between the core and data_mem
//
// Purpose: groups the memory-port bus signals of data_mem.
// Signals:
//   addr        32  byte address
//   read_op     3   LB=000 LH=001 LW=010 LBU=100 LHU=101 LNONE=111
//   write_op    2   SB=00 SH=01 SW=10 SNONE=11
//   write_data  32  store data, right-aligned
//   read_data   32  extended load result of the last accepted read
// Modports: master (CPU side), slave (memory side).
interface data_mem_if;
  logic [31:0] addr;
  logic [2:0]  read_op;
  logic [1:0]  write_op;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output addr, read_op, write_op, write_data, input read_data);
  modport slave  (input addr, read_op, write_op, write_data, output read_data);
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-wide RAM with byte/half/word access and a small I/O page
//
// Purpose: memory responder on the CPU memory port. Byte/half/word loads and
//   stores on a word-wide RAM, 1-cycle load latency with sign/zero extension,
//   an LED register and a free-running cycle counter in the I/O page
//   0xFFFFFFF0..0xFFFFFFFF, and a sticky misaligned-access flag.
// Ports:
//   clk       in   clock, all state changes on rising edge
//   reset_n   in   synchronous active-low reset
//   bus       slave modport of data_mem_if (addr/read_op/write_op/write_data/read_data)
//   leds      out  8-bit LED register
//   fault     out  sticky misaligned-access flag
module data_mem #(
  parameter int    MEM_ADDR_BITS = 10,
  parameter string INIT_FILE     = ""
) (
  input  logic       clk,
  input  logic       reset_n,
  data_mem_if.slave  bus,
  output logic [7:0] leds,
  output logic       fault
);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [1:0] OP_SB  = 2'b00;
  localparam logic [1:0] OP_SH  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_SNONE = 2'b11;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_word;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_counter;
  logic [7:0]  r_leds;
  logic        r_fault;

  logic                     w_is_io;
  logic [MEM_ADDR_BITS-1:0] w_idx;
  logic                     w_rd_en;
  logic                     w_wr_en;
  logic                     w_rd_mis;
  logic                     w_wr_mis;
  logic                     w_wr_ok;
  logic [31:0]              w_rd_word;
  logic [3:0]               w_be;
  logic [31:0]              w_wdata;
  logic [31:0]              w_lane_word;

  assign w_is_io = (bus.addr[31:4] == 28'hFFFFFFF);
  assign w_idx   = bus.addr[MEM_ADDR_BITS+1:2];

  // Undefined read encodings (011, 110) fall out as "no read" here.
  assign w_rd_en = (bus.read_op == OP_LB) || (bus.read_op == OP_LH) ||
                   (bus.read_op == OP_LW) || (bus.read_op == OP_LBU) ||
                   (bus.read_op == OP_LHU);
  assign w_wr_en = (bus.write_op != OP_SNONE);

  assign w_rd_mis = w_rd_en &&
                    ((((bus.read_op == OP_LH) || (bus.read_op == OP_LHU)) && bus.addr[0]) ||
                     ((bus.read_op == OP_LW) && (bus.addr[1:0] != 2'b00)));
  assign w_wr_mis = w_wr_en &&
                    (((bus.write_op == OP_SH) && bus.addr[0]) ||
                     ((bus.write_op == OP_SW) && (bus.addr[1:0] != 2'b00)));
  assign w_wr_ok  = w_wr_en && !w_wr_mis;

  always_comb begin
    w_rd_word = 32'h0;
    if (w_is_io) begin
      case (bus.addr[3:2])
        2'd0:    w_rd_word = {24'h0, r_leds};
        2'd1:    w_rd_word = r_counter;
        default: w_rd_word = 32'h0;
      endcase
    end else begin
      w_rd_word = r_mem[w_idx];
    end
  end

  // Store data is replicated across lanes so only the byte enables pick placement.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = bus.write_data;
    case (bus.write_op)
      OP_SB: begin
        w_be    = 4'b0001 << bus.addr[1:0];
        w_wdata = {4{bus.write_data[7:0]}};
      end
      OP_SH: begin
        w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.write_data[15:0]}};
      end
      OP_SW:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM has no reset; reset only blocks a coincident store.
  always_ff @(posedge clk) begin
    if (reset_n && w_wr_ok && !w_is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_word    <= 32'h0;
      r_op      <= OP_LW;
      r_off     <= 2'b00;
      r_counter <= 32'h0;
      r_leds    <= 8'h0;
      r_fault   <= 1'b0;
    end else begin
      r_counter <= r_counter + 32'd1;
      if (w_rd_en) begin
        r_word <= w_rd_mis ? 32'h0 : w_rd_word;
        r_op   <= bus.read_op;
        r_off  <= bus.addr[1:0];
      end
      if (w_rd_mis || w_wr_mis) r_fault <= 1'b1;
      // LED register takes any store size, but only if lane 0 is written.
      if (w_wr_ok && w_is_io && (bus.addr[3:2] == 2'd0) && w_be[0]) begin
        r_leds <= bus.write_data[7:0];
      end
    end
  end

  assign w_lane_word = r_word >> {r_off, 3'b000};

  always_comb begin
    bus.read_data = r_word;
    case (r_op)
      OP_LB:   bus.read_data = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
      OP_LBU:  bus.read_data = {24'h0, w_lane_word[7:0]};
      OP_LH:   bus.read_data = r_off[1] ? {{16{r_word[31]}}, r_word[31:16]}
                                        : {{16{r_word[15]}}, r_word[15:0]};
      OP_LHU:  bus.read_data = r_off[1] ? {16'h0, r_word[31:16]} : {16'h0, r_word[15:0]};
      default: bus.read_data = r_word;
    endcase
  end

  assign leds  = r_leds;
  assign fault = r_fault;
endmodule
